// File: rtl/display_timing_gen_pkg.sv
// Shared raster timing constants, payload types and derivation helpers
// for the display timing generator.
package display_timing_pkg;

    localparam int COORD_W      = 32'sd16;
    localparam int MAX_TOTAL    = 32'sd65535;
    localparam int MAX_PIPE_LAT = 32'sd4;

    // 640x480@60 reference timing
    localparam int DEF_H_ACTIVE = 32'sd640;
    localparam int DEF_H_FP     = 32'sd16;
    localparam int DEF_H_SYNC   = 32'sd96;
    localparam int DEF_H_BP     = 32'sd48;
    localparam int DEF_V_ACTIVE = 32'sd480;
    localparam int DEF_V_FP     = 32'sd10;
    localparam int DEF_V_SYNC   = 32'sd2;
    localparam int DEF_V_BP     = 32'sd33;
    localparam int DEF_PIPE_LAT = 32'sd1;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // Control bits already carry their PHY polarity when they enter the delay line.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic de;
    } phy_ctrl_t;

    function automatic int calc_h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic phy_ctrl_t phy_idle(input bit h_pol, input bit v_pol);
        phy_ctrl_t idle;
        idle.h_sync = ~h_pol;
        idle.v_sync = ~v_pol;
        idle.de     = 1'b0;
        return idle;
    endfunction

endpackage

// File: rtl/display_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with a synchronous reset pattern; exposes the
// last stage and the value about to enter it.
module sync_delay_line #(
    parameter int               DEPTH   = 32'sd1,
    parameter int               WIDTH   = 32'sd3,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 32'sd1) begin : g_bad_depth
        $error("sync_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift stages, every stage reloads the reset pattern on rst
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 32'sd1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

    if (DEPTH == 32'sd1) begin : g_tap_din
        assign tap = din;
    end else begin : g_tap_stage
        assign tap = stage_r[DEPTH-2];
    end

endmodule

// File: rtl/display_timing_gen.sv
// Raster counter, coordinate decode and PHY-aligned sync/DE/RGB output stage.
// Coordinates go to gfx; the returned RGB meets delayed sync/DE at the outputs.
module display_timing_gen
    import display_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = POL_ACTIVE_LOW,
    parameter bit V_POL    = POL_ACTIVE_LOW,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_active,
    output logic        o_frame_start,
    output logic        o_line_start,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_de,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue
);

    localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_bad_total
        $error("display_timing_gen: H_TOTAL or V_TOTAL exceeds the 16-bit counter range");
    end
    if ((PIPE_LAT < 32'sd0) || (PIPE_LAT > MAX_PIPE_LAT)) begin : g_bad_lat
        $error("display_timing_gen: PIPE_LAT must be within 0..4");
    end

    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 32'sd1);
    localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 32'sd1);
    localparam logic [15:0] H_ACT_END = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_END = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC - 32'sd1);
    localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC - 32'sd1);

    localparam phy_ctrl_t CTRL_IDLE = phy_idle(H_POL, V_POL);

    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [15:0] x_next_s;
    logic [15:0] y_next_s;
    logic        active_r;
    logic        frame_start_r;
    logic        line_start_r;
    logic        active_next_s;
    logic        hs_next_s;
    logic        vs_next_s;
    phy_ctrl_t   ctrl_r;
    phy_ctrl_t   tap_s;
    phy_ctrl_t   dl_out_s;
    logic [7:0]  red_r;
    logic [7:0]  green_r;
    logic [7:0]  blue_r;

    // Next raster position: x wraps each line, y advances only on that wrap
    always_comb begin
        x_next_s = x_r + 16'd1;
        y_next_s = y_r;
        if (x_r == H_LAST) begin
            x_next_s = 16'd0;
            if (y_r == V_LAST) begin
                y_next_s = 16'd0;
            end else begin
                y_next_s = y_r + 16'd1;
            end
        end else begin
            x_next_s = x_r + 16'd1;
            y_next_s = y_r;
        end
    end

    // Region decode of the upcoming position so flags land with the coordinates
    always_comb begin
        active_next_s = (x_next_s < H_ACT_END) && (y_next_s < V_ACT_END);
        hs_next_s     = (x_next_s >= HS_START) && (x_next_s <= HS_END);
        vs_next_s     = (y_next_s >= VS_START) && (y_next_s <= VS_END);
    end

    // Raster counters and undelayed decode registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_r           <= H_LAST;
            y_r           <= V_LAST;
            active_r      <= 1'b0;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
            ctrl_r        <= CTRL_IDLE;
        end else begin
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            active_r      <= active_next_s;
            frame_start_r <= (x_next_s == 16'd0) && (y_next_s == 16'd0);
            line_start_r  <= (x_next_s == 16'd0);
            ctrl_r.h_sync <= hs_next_s ^ ~H_POL;
            ctrl_r.v_sync <= vs_next_s ^ ~V_POL;
            ctrl_r.de     <= active_next_s;
        end
    end

    // Last stage lines up with the RGB register; tap is the stage in step with gfx data
    sync_delay_line #(
        .DEPTH   (PIPE_LAT + 32'sd1),
        .WIDTH   ($bits(phy_ctrl_t)),
        .RST_VAL (CTRL_IDLE)
    ) u_sync_delay (
        .clk  (i_clk),
        .rst  (i_rst),
        .din  (ctrl_r),
        .tap  (tap_s),
        .dout (dl_out_s)
    );

    // RGB capture with blanking outside the visible area
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            red_r   <= 8'd0;
            green_r <= 8'd0;
            blue_r  <= 8'd0;
        end else if (tap_s.de) begin
            red_r   <= i_red;
            green_r <= i_green;
            blue_r  <= i_blue;
        end else begin
            red_r   <= 8'd0;
            green_r <= 8'd0;
            blue_r  <= 8'd0;
        end
    end

    assign o_x           = x_r;
    assign o_y           = y_r;
    assign o_active      = active_r;
    assign o_frame_start = frame_start_r;
    assign o_line_start  = line_start_r;
    assign o_h_sync      = dl_out_s.h_sync;
    assign o_v_sync      = dl_out_s.v_sync;
    assign o_de          = dl_out_s.de;
    assign o_red         = red_r;
    assign o_green       = green_r;
    assign o_blue        = blue_r;

endmodule
